// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a DEPTH-entry prefetch queue,
// redirect flush and a sticky halt on misaligned redirect targets.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_misaligned,
  output logic [XLEN-1:0] fault_pc
);

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tag_q, tag_d;
  logic [XLEN-1:0] fault_q, fault_d;
  logic            inflight_q, inflight_d;
  logic            mis_q, mis_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;

  logic [XLEN-1:0] ins_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q  [DEPTH];

  logic req;
  logic grant;
  logic push;
  logic pop;
  logic valid;
  logic aligned;

  assign valid   = (cnt_q != '0);
  assign aligned = (redirect_pc[1:0] == 2'b00);

  // Credit check counts the in-flight response so the queue never overflows
  assign req = (state_q == FETCH) && fetch_en && !redirect_valid && !rst &&
               ((cnt_q + CW'(inflight_q)) < DEPTH_C);

  assign grant = req && imem_gnt;
  assign push  = inflight_q && !redirect_valid && !rst;
  assign pop   = valid && instr_ready && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tag_d      = tag_q;
    fault_d    = fault_q;
    inflight_d = 1'b0;
    mis_d      = mis_q;
    cnt_d      = cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      cnt_d  = '0;
      head_d = '0;
      tail_d = '0;
      if (aligned) begin
        state_d = FETCH;
        mis_d   = 1'b0;
      end else begin
        state_d = HALT;
        mis_d   = 1'b1;
        fault_d = redirect_pc;
      end
    end else begin
      if (grant) begin
        pc_d       = pc_q + XLEN'(4);
        tag_d      = pc_q;
        inflight_d = 1'b1;
      end
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      fault_q    <= '0;
      inflight_q <= 1'b0;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      fault_q    <= fault_d;
      inflight_q <= inflight_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem_q[tail_q] <= imem_rdata;
      pc_mem_q[tail_q]  <= tag_q;
    end
  end

  assign imem_req         = req;
  assign imem_addr        = pc_q;
  assign instr_valid      = valid;
  assign instr_out        = valid ? ins_mem_q[head_q] : '0;
  assign instr_pc         = valid ? pc_mem_q[head_q] : '0;
  assign fetch_misaligned = mis_q;
  assign fault_pc         = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic
// checked against a transaction-level queue model.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetch_en, imem_req, imem_gnt;
  logic        instr_valid, instr_ready, redirect_valid;
  logic        fetch_misaligned;
  logic [31:0] imem_addr, imem_rdata, instr_out, instr_pc;
  logic [31:0] redirect_pc, fault_pc;

  logic        w_rst, w_fen, w_req, w_gnt;
  logic        w_valid, w_rdy, w_rv, w_mis;
  logic [31:0] w_addr, w_rdata, w_iout, w_ipc, w_rpc, w_fault;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_misaligned(fetch_misaligned), .fault_pc(fault_pc)
  );

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(w_rst), .fetch_en(w_fen),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rdata(w_rdata),
    .instr_valid(w_valid), .instr_ready(w_rdy),
    .instr_out(w_iout), .instr_pc(w_ipc),
    .redirect_valid(w_rv), .redirect_pc(w_rpc),
    .fetch_misaligned(w_mis), .fault_pc(w_fault)
  );

  int total = 0;
  int bad   = 0;
  int gcnt  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_fault, m_pend_pc;
  bit          m_halt, m_mis, m_pend, m_known;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit fe, input bit g,
                     input bit rd, input bit rv,
                     input logic [31:0] rp);
    bit          req, pop, grant;
    ent_t        e;
    logic [31:0] hp, hi;
    @(negedge clk);
    rst            = r;
    fetch_en       = fe;
    imem_gnt       = g;
    instr_ready    = rd;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_rdata     = m_pend ? word(m_pend_pc) : $urandom;
    #1;
    req = !r && !m_halt && fe && !rv &&
          (mq.size() + int'(m_pend) < DEPTH);
    if (m_known) begin
      hp = (mq.size() != 0) ? mq[0].pc  : 32'h0;
      hi = (mq.size() != 0) ? mq[0].ins : 32'h0;
      chk("req",   32'(imem_req), 32'(req));
      chk("addr",  imem_addr, m_pc);
      chk("valid", 32'(instr_valid), 32'(mq.size() != 0));
      chk("ipc",   instr_pc, hp);
      chk("iout",  instr_out, hi);
      chk("mis",   32'(fetch_misaligned), 32'(m_mis));
      chk("fault", fault_pc, m_fault);
    end
    if (imem_req && g) gcnt++;
    if (r) begin
      mq.delete();
      m_pend  = 0;
      m_pc    = 32'h0;
      m_halt  = 0;
      m_mis   = 0;
      m_fault = 32'h0;
      m_known = 1;
    end else if (rv) begin
      mq.delete();
      m_pend = 0;
      m_pc   = rp;
      if (rp[1:0] != 2'b00) begin
        m_halt  = 1;
        m_mis   = 1;
        m_fault = rp;
      end else begin
        m_halt = 0;
        m_mis  = 0;
      end
    end else begin
      pop = (mq.size() != 0) && rd;
      if (pop) mq.delete(0);
      if (m_pend) begin
        e.pc  = m_pend_pc;
        e.ins = word(m_pend_pc);
        mq.push_back(e);
      end
      grant  = req && g;
      m_pend = grant;
      if (grant) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
  endtask

  logic [31:0] wexp [4];
  logic [31:0] w_last;
  bit          w_lastv;
  int          wgot;

  initial begin
    bit          r, rv;
    logic [31:0] rp;

    m_known = 0;
    m_pend  = 0;
    w_rst = 1; w_fen = 1; w_gnt = 1; w_rdy = 1;
    w_rv = 0; w_rpc = 0; w_rdata = 0;

    // streaming from reset
    repeat (2) cyc(1, 1, 1, 1, 0, 0);
    repeat (10) cyc(0, 1, 1, 1, 0, 0);

    // back-pressure fills the queue
    repeat (2) cyc(1, 1, 1, 1, 0, 0);
    gcnt = 0;
    repeat (8) cyc(0, 1, 1, 0, 0, 0);
    chk("stall_grants", gcnt, 4);
    repeat (8) cyc(0, 1, 1, 1, 0, 0);

    // redirect with 2 queued and one in flight
    repeat (2) cyc(1, 1, 1, 1, 0, 0);
    repeat (3) cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 32'h100);
    repeat (6) cyc(0, 1, 1, 1, 0, 0);

    // misaligned redirect halts until an aligned one
    cyc(0, 1, 1, 1, 1, 32'h102);
    repeat (5) cyc(0, 1, 1, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("halt_mis",   32'(fetch_misaligned), 32'd1);
    chk("halt_fault", fault_pc, 32'h102);
    chk("halt_req",   32'(imem_req), 32'd0);
    cyc(0, 1, 1, 1, 1, 32'h200);
    repeat (6) cyc(0, 1, 1, 1, 0, 0);

    // grant pattern 1,0,0,1
    for (int i = 0; i < 16; i++)
      cyc(0, 1, (i % 4 == 0) || (i % 4 == 3), 1, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(63) == 0);
      rv = ($urandom_range(15) == 0);
      rp = $urandom & 32'h0000_0FFC;
      if ($urandom_range(7) == 0) rp = 32'hFFFF_FFF0;
      if ($urandom_range(7) == 0) rp[1:0] = 2'($urandom_range(3, 1));
      cyc(r, $urandom_range(99) < 85, $urandom_range(99) < 70,
          $urandom_range(99) < 60, rv, rp);
    end

    // PC wrap on the second instance
    rst = 1;
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    wexp[3] = 32'h0000_0004;
    @(negedge clk);
    w_rst = 1;
    @(negedge clk);
    w_rst   = 0;
    w_lastv = 0;
    w_last  = 0;
    wgot    = 0;
    for (int c = 0; c < 20 && wgot < 4; c++) begin
      w_rdata = w_lastv ? word(w_last) : 32'h0;
      #1;
      if (c == 0) chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
      if (w_valid && w_rdy) begin
        chk("wrap_pc",  w_ipc,  wexp[wgot]);
        chk("wrap_ins", w_iout, word(wexp[wgot]));
        wgot++;
      end
      w_lastv = w_req && w_gnt;
      w_last  = w_addr;
      @(negedge clk);
    end
    chk("wrap_cnt", wgot, 4);

    // reset mid-stream empties the queue
    w_rdy = 0;
    for (int c = 0; c < 4; c++) begin
      w_rdata = w_lastv ? word(w_last) : 32'h0;
      #1;
      w_lastv = w_req && w_gnt;
      w_last  = w_addr;
      @(negedge clk);
    end
    chk("wrap_pre_valid", 32'(w_valid), 32'd1);
    w_rst = 1;
    @(posedge clk);
    #1;
    chk("wrap_rst_valid", 32'(w_valid), 32'd0);
    chk("wrap_rst_req",   32'(w_req), 32'd0);
    chk("wrap_rst_addr",  w_addr, 32'hFFFF_FFF8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
